// File: rtl/div_unit_pkg.sv
// Shared types and helpers for the iterative 32-bit divider.
// Holds the FSM state encoding, the datapath widths and the sign fix-up helper.
package div_unit_pkg;

  localparam int DIV_W        = 32;
  localparam int DIV_RESULT_W = 2 * DIV_W;
  localparam int DIV_WORK_W   = 2 * DIV_W + 1;
  localparam int DIV_CNT_W    = 6;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX-stage <-> divider bus: operands and control in, result, ready and stall request out.
interface div_unit_if;
  import div_unit_pkg::*;

  logic                    div_start;
  logic                    div_signed;
  logic                    div_annul;
  logic [DIV_W-1:0]        div_opdata1;
  logic [DIV_W-1:0]        div_opdata2;
  logic [DIV_RESULT_W-1:0] div_result;
  logic                    div_ready;
  logic                    stallreq_for_div;

  modport master (
    output div_start, div_signed, div_annul, div_opdata1, div_opdata2,
    input  div_result, div_ready, stallreq_for_div
  );

  modport slave (
    input  div_start, div_signed, div_annul, div_opdata1, div_opdata2,
    output div_result, div_ready, stallreq_for_div
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on the 65-bit {rem[32:0], quo[31:0]} work register:
// shift left, trial-subtract the divisor, keep the difference and set a quotient bit if it fits.
module div_step
  import div_unit_pkg::*;
(
  input  logic [DIV_WORK_W-1:0] i_work,
  input  logic [DIV_W-1:0]      i_divisor,
  output logic [DIV_WORK_W-1:0] o_work
);

  logic                  w_unused_msb;
  logic [DIV_WORK_W-1:0] w_shifted;
  logic [DIV_W:0]        w_diff;

  // rem never exceeds the divisor, so the top bit shifted out is always zero.
  assign w_unused_msb = i_work[DIV_WORK_W-1];
  assign w_shifted    = {i_work[DIV_WORK_W-2:0], 1'b0};
  assign w_diff       = w_shifted[DIV_WORK_W-1:DIV_W] - {1'b0, i_divisor};

  always_comb begin
    o_work = w_shifted;
    if (!w_diff[DIV_W]) o_work = {w_diff, w_shifted[DIV_W-1:1], 1'b1};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU for the EX stage: 32 restoring steps, stall request while busy,
// {remainder, quotient} presented with a one-cycle ready pulse.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  div_state_e              r_state;
  div_state_e              w_next;
  logic [DIV_CNT_W-1:0]    r_cnt;
  logic [DIV_WORK_W-1:0]   r_work;
  logic [DIV_WORK_W-1:0]   w_work_next;
  logic [DIV_W-1:0]        r_divisor;
  logic                    r_neg_q;
  logic                    r_neg_r;
  logic [DIV_RESULT_W-1:0] r_result;
  logic                    w_stall;
  logic                    w_ready;
  logic                    w_last;
  logic                    w_op1_neg;
  logic                    w_op2_neg;

  assign w_last    = (r_cnt == DIV_CNT_W'(DIV_W - 1));
  assign w_op1_neg = bus.div_signed & bus.div_opdata1[DIV_W-1];
  assign w_op2_neg = bus.div_signed & bus.div_opdata2[DIV_W-1];

  div_step u_step (
    .i_work    (r_work),
    .i_divisor (r_divisor),
    .o_work    (w_work_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DIV_FREE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_ready = 1'b0;
    unique case (r_state)
      DIV_FREE: begin
        if (bus.div_start) begin
          w_stall = 1'b1;
          w_next  = (bus.div_opdata2 == '0) ? DIV_BYZERO : DIV_ON;
        end
      end
      DIV_BYZERO: begin
        w_stall = 1'b1;
        w_next  = DIV_END;
      end
      DIV_ON: begin
        w_stall = 1'b1;
        if (w_last) w_next = DIV_END;
      end
      DIV_END: begin
        w_ready = 1'b1;
        w_next  = DIV_FREE;
      end
      default: w_next = DIV_FREE;
    endcase
    // An EX flush wins over everything, including a start in the same cycle.
    if (bus.div_annul) begin
      w_next  = DIV_FREE;
      w_stall = 1'b0;
      w_ready = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
    end else begin
      unique case (r_state)
        DIV_FREE: begin
          if (w_next == DIV_ON) begin
            r_work    <= {{(DIV_W+1){1'b0}}, cond_neg(bus.div_opdata1, w_op1_neg)};
            r_divisor <= cond_neg(bus.div_opdata2, w_op2_neg);
            r_neg_q   <= w_op1_neg ^ w_op2_neg;
            r_neg_r   <= w_op1_neg;
            r_cnt     <= '0;
          end
        end
        DIV_BYZERO: begin
          if (!bus.div_annul) r_result <= '0;
        end
        DIV_ON: begin
          if (!bus.div_annul) begin
            r_work <= w_work_next;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last)
              r_result <= {cond_neg(w_work_next[2*DIV_W-1:DIV_W], r_neg_r),
                           cond_neg(w_work_next[DIV_W-1:0], r_neg_q)};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.div_result       = r_result;
  assign bus.div_ready        = w_ready;
  assign bus.stallreq_for_div = w_stall;

endmodule
